// File: rtl/satagtx_rst_seq_if.sv
// Lock indications in, reset controls and status out, for the SATA GTX/GTP reset sequencer.
interface satagtx_rst_seq_if;
  logic       tile0_plllkdet;
  logic       refclkout_dcm0_locked;
  logic       tile0_resetdone;
  logic       gtx_reset;
  logic       user_rst;
  logic       link_ready;
  logic [3:0] retry_cnt;
  logic       lock_err;
  logic [2:0] seq_state;

  // Sequencer side: consumes lock indications, drives resets and status
  modport master (
    input  tile0_plllkdet,
    input  refclkout_dcm0_locked,
    input  tile0_resetdone,
    output gtx_reset,
    output user_rst,
    output link_ready,
    output retry_cnt,
    output lock_err,
    output seq_state
  );

  // Tile / clocking side: drives lock indications, observes resets and status
  modport slave (
    output tile0_plllkdet,
    output refclkout_dcm0_locked,
    output tile0_resetdone,
    input  gtx_reset,
    input  user_rst,
    input  link_ready,
    input  retry_cnt,
    input  lock_err,
    input  seq_state
  );
endinterface

// File: rtl/satagtx_rst_seq.sv
// Power-up and lock-loss reset sequencer for the SATA GTX/GTP tile.
// Runs on the free-running fabric clock; all lock inputs are resynchronised.
module satagtx_rst_seq #(
  parameter int unsigned C_GTXRST_CYCLES = 16,
  parameter int unsigned C_LOCK_TIMEOUT  = 50000,
  parameter int unsigned C_SETTLE_CYCLES = 256,
  parameter int unsigned C_MAX_RETRY     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  satagtx_rst_seq_if.master bus
);

  typedef enum logic [2:0] {
    StReset    = 3'd0,
    StWaitPll  = 3'd1,
    StWaitDcm  = 3'd2,
    StWaitDone = 3'd3,
    StSettle   = 3'd4,
    StReady    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  retry_cnt_q, retry_cnt_d;
  logic        lock_err_q, lock_err_d;
  logic        gtx_reset_q, user_rst_q, link_ready_q;
  logic [1:0]  pll_sync_q, dcm_sync_q, done_sync_q;
  logic        pll_s, dcm_s, done_s, all_s;
  logic        timeout, retry;

  // Two-flop synchronisers for the asynchronous lock indications
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_sync_q  <= 2'b00;
      dcm_sync_q  <= 2'b00;
      done_sync_q <= 2'b00;
    end else begin
      pll_sync_q  <= {pll_sync_q[0], bus.tile0_plllkdet};
      dcm_sync_q  <= {dcm_sync_q[0], bus.refclkout_dcm0_locked};
      done_sync_q <= {done_sync_q[0], bus.tile0_resetdone};
    end
  end

  assign pll_s   = pll_sync_q[1];
  assign dcm_s   = dcm_sync_q[1];
  assign done_s  = done_sync_q[1];
  assign all_s   = pll_s & dcm_s & done_s;
  assign timeout = (timer_q == 16'(C_LOCK_TIMEOUT - 1));

  // Next-state decode; an arriving input beats a timeout on the same cycle
  always_comb begin
    state_d = state_q;
    retry   = 1'b0;
    unique case (state_q)
      StReset: begin
        if (timer_q == 16'(C_GTXRST_CYCLES - 1)) state_d = StWaitPll;
      end
      StWaitPll: begin
        if (pll_s)        state_d = StWaitDcm;
        else if (timeout) retry   = 1'b1;
      end
      StWaitDcm: begin
        if (!pll_s)       retry   = 1'b1;
        else if (dcm_s)   state_d = StWaitDone;
        else if (timeout) retry   = 1'b1;
      end
      StWaitDone: begin
        if (!pll_s || !dcm_s) retry   = 1'b1;
        else if (done_s)      state_d = StSettle;
        else if (timeout)     retry   = 1'b1;
      end
      StSettle: begin
        if (!all_s) retry = 1'b1;
        else if (timer_q == 16'(C_SETTLE_CYCLES - 1)) state_d = StReady;
      end
      StReady: begin
        if (!all_s) retry = 1'b1;
      end
      default: state_d = StReset;
    endcase
    if (retry) state_d = StReset;
  end

  // Timer restarts on every state change; retry counter saturates, error is sticky
  always_comb begin
    timer_d     = timer_q;
    retry_cnt_d = retry_cnt_q;
    lock_err_d  = lock_err_q;
    if (state_d != state_q)    timer_d = 16'd0;
    else if (timer_q != 16'hFFFF) timer_d = timer_q + 16'd1;
    if (retry && retry_cnt_q != 4'hF) retry_cnt_d = retry_cnt_q + 4'd1;
    if (retry_cnt_d >= 4'(C_MAX_RETRY)) lock_err_d = 1'b1;
  end

  // State, counters and registered outputs (outputs follow the next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StReset;
      timer_q      <= 16'd0;
      retry_cnt_q  <= 4'd0;
      lock_err_q   <= 1'b0;
      gtx_reset_q  <= 1'b1;
      user_rst_q   <= 1'b1;
      link_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_cnt_q  <= retry_cnt_d;
      lock_err_q   <= lock_err_d;
      gtx_reset_q  <= (state_d == StReset);
      user_rst_q   <= (state_d != StReady);
      link_ready_q <= (state_d == StReady);
    end
  end

  assign bus.gtx_reset  = gtx_reset_q;
  assign bus.user_rst   = user_rst_q;
  assign bus.link_ready = link_ready_q;
  assign bus.retry_cnt  = retry_cnt_q;
  assign bus.lock_err   = lock_err_q;
  assign bus.seq_state  = state_q;

endmodule

// File: tb/tb_satagtx_rst_seq.sv
// Directed bench for the SATA GTX reset sequencer.
module tb_satagtx_rst_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  satagtx_rst_seq_if bus ();

  satagtx_rst_seq #(
    .C_GTXRST_CYCLES(16),
    .C_LOCK_TIMEOUT (1000),
    .C_SETTLE_CYCLES(256),
    .C_MAX_RETRY    (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic pll, input logic dcm, input logic done);
    bus.tile0_plllkdet        = pll;
    bus.refclkout_dcm0_locked = dcm;
    bus.tile0_resetdone       = done;
  endtask

  // Sample now, then once per clk, counting how long gtx_reset stays high
  task automatic count_gtx_high(output int n);
    n = 0;
    while (bus.gtx_reset === 1'b1 && n < 100) begin
      n++;
      tick(1);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    int k = 0;
    while (bus.seq_state !== target && k < budget) begin
      k++;
      tick(1);
    end
    check(tag, 16'(bus.seq_state), 16'(target));
  endtask

  task automatic do_reset(input logic pll, input logic dcm, input logic done);
    rst_n = 1'b0;
    tick(2);
    set_inputs(pll, dcm, done);
    rst_n = 1'b1;
  endtask

  initial begin
    int   n;
    logic seen;
    int   exp_retry;

    rst_n = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0);
    tick(3);
    check("rst_gtx", 16'(bus.gtx_reset), 16'd1);
    check("rst_user", 16'(bus.user_rst), 16'd1);
    check("rst_ready", 16'(bus.link_ready), 16'd0);
    check("rst_retry", 16'(bus.retry_cnt), 16'd0);
    check("rst_err", 16'(bus.lock_err), 16'd0);
    check("rst_state", 16'(bus.seq_state), 16'd0);

    // Clean bring-up
    rst_n = 1'b1;
    count_gtx_high(n);
    check("up_gtx_len", 16'(n), 16'd16);
    check("up_wpll", 16'(bus.seq_state), 16'd1);
    tick(100); bus.tile0_plllkdet = 1'b1;
    tick(2);   check("up_pll_lat", 16'(bus.seq_state), 16'd1);
    tick(1);   check("up_wdcm", 16'(bus.seq_state), 16'd2);
    tick(100); bus.refclkout_dcm0_locked = 1'b1;
    tick(2);   check("up_dcm_lat", 16'(bus.seq_state), 16'd2);
    tick(1);   check("up_wdone", 16'(bus.seq_state), 16'd3);
    tick(100); bus.tile0_resetdone = 1'b1;
    tick(2);   check("up_done_lat", 16'(bus.seq_state), 16'd3);
    tick(1);   check("up_settle", 16'(bus.seq_state), 16'd4);
    tick(255);
    check("up_settle_end", 16'(bus.link_ready), 16'd0);
    tick(1);
    check("up_ready", 16'(bus.link_ready), 16'd1);
    check("up_user", 16'(bus.user_rst), 16'd0);
    check("up_state", 16'(bus.seq_state), 16'd5);
    check("up_retry", 16'(bus.retry_cnt), 16'd0);
    check("up_err", 16'(bus.lock_err), 16'd0);

    // Lock loss in READY: one-cycle DCM drop
    bus.refclkout_dcm0_locked = 1'b0;
    tick(1); bus.refclkout_dcm0_locked = 1'b1;
    tick(1); check("ll_still_ready", 16'(bus.link_ready), 16'd1);
    tick(1);
    check("ll_ready", 16'(bus.link_ready), 16'd0);
    check("ll_user", 16'(bus.user_rst), 16'd1);
    check("ll_state", 16'(bus.seq_state), 16'd0);
    check("ll_retry", 16'(bus.retry_cnt), 16'd1);
    count_gtx_high(n);
    check("ll_gtx_len", 16'(n), 16'd16);
    tick(3);   check("ll_settle", 16'(bus.seq_state), 16'd4);
    tick(256); check("ll_ready_again", 16'(bus.link_ready), 16'd1);

    // Glitch on resetdone at settle count 200
    do_reset(1'b1, 1'b1, 1'b1);
    wait_state("gl_settle", 3'd4, 400);
    tick(200);
    bus.tile0_resetdone = 1'b0;
    seen = 1'b0;
    tick(1); bus.tile0_resetdone = 1'b1; seen = seen | bus.link_ready;
    tick(1); seen = seen | bus.link_ready;
    check("gl_hold", 16'(bus.seq_state), 16'd4);
    tick(1); seen = seen | bus.link_ready;
    check("gl_state", 16'(bus.seq_state), 16'd0);
    check("gl_retry", 16'(bus.retry_cnt), 16'd1);
    check("gl_no_ready", 16'(seen), 16'd0);

    // Boundary: pll_s arrives exactly on the timeout cycle
    do_reset(1'b0, 1'b0, 1'b0);
    wait_state("bd_wpll", 3'd1, 40);
    tick(997); bus.tile0_plllkdet = 1'b1;
    tick(2);   check("bd_hold", 16'(bus.seq_state), 16'd1);
    tick(1);
    check("bd_wdcm", 16'(bus.seq_state), 16'd2);
    check("bd_retry", 16'(bus.retry_cnt), 16'd0);

    // PLL timeout, retry saturation and lock_err
    do_reset(1'b0, 1'b0, 1'b0);
    wait_state("to_wpll", 3'd1, 40);
    tick(999); check("to_hold", 16'(bus.seq_state), 16'd1);
    tick(1);
    check("to_state1", 16'(bus.seq_state), 16'd0);
    check("to_retry1", 16'(bus.retry_cnt), 16'd1);
    check("to_err1", 16'(bus.lock_err), 16'd0);
    for (int k = 2; k <= 16; k++) begin
      exp_retry = (k > 15) ? 15 : k;
      tick(1015); check("to_period_hold", 16'(bus.seq_state), 16'd1);
      tick(1);
      check("to_period_state", 16'(bus.seq_state), 16'd0);
      check("to_retry", 16'(bus.retry_cnt), 16'(exp_retry));
      check("to_err", 16'(bus.lock_err), (exp_retry >= 8) ? 16'd1 : 16'd0);
    end

    // READY after lock_err keeps it set
    set_inputs(1'b1, 1'b1, 1'b1);
    wait_state("err_ready", 3'd5, 400);
    check("err_sticky", 16'(bus.lock_err), 16'd1);
    check("err_retry", 16'(bus.retry_cnt), 16'd15);

    // Asynchronous reset while in WAIT_DONE
    bus.tile0_resetdone = 1'b0;
    wait_state("ar_wdone", 3'd3, 400);
    #3 rst_n = 1'b0;
    #1;
    check("ar_gtx", 16'(bus.gtx_reset), 16'd1);
    check("ar_user", 16'(bus.user_rst), 16'd1);
    check("ar_ready", 16'(bus.link_ready), 16'd0);
    check("ar_retry", 16'(bus.retry_cnt), 16'd0);
    check("ar_err", 16'(bus.lock_err), 16'd0);
    check("ar_state", 16'(bus.seq_state), 16'd0);
    #2 rst_n = 1'b1;
    count_gtx_high(n);
    check("ar_gtx_len", 16'(n), 16'd16);
    check("ar_retry_after", 16'(bus.retry_cnt), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
